mul_unit: RTL

Iterative multiplier for the execute stage of the pipelined ARM core. It is the producer side of the flag path: it generates `ALUFlags` and results for MUL, MLA, UMULL and SMULL, which the condition unit then latches under `FlagWriteE`. The block holds the pipeline through a stall/done handshake with the hazard unit while it runs a radix-2 shift-add over `WIDTH` cycles.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/flopenr.sv | 18 +
 rtl/mul_ctrl.sv | 80 ++++++++
 rtl/mul_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiplier: operation selects and FSM states.
package mul_pkg;

    localparam logic [1:0] MUL_OP   = 2'b00;
    localparam logic [1:0] MLA_OP   = 2'b01;
    localparam logic [1:0] UMULL_OP = 2'b10;
    localparam logic [1:0] SMULL_OP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    // Long multiplies (UMULL/SMULL) produce a 2*WIDTH result.
    function automatic logic is_long_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/flopenr.sv
// Resettable flop with enable: synchronous active-high reset clears, en loads d.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register with clear-over-load priority.
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mul_ctrl.sv
// Multiplier sequencer: IDLE/CALC/FIX/DONE FSM, step counter, pipeline stall and Done.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic StartE,
    input  logic FlushE,
    output logic StallMul,
    output logic Done,
    output logic load_o,    // accept a start: load operands into the datapath
    output logic step_o,    // perform one shift-add step this cycle
    output logic res_en_o   // capture fixed-up results and flags
);

    localparam int CW = $clog2(WIDTH) + 1;

    mul_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and step counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and handshake decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        StallMul = 1'b0;
        Done     = 1'b0;
        load_o   = 1'b0;
        step_o   = 1'b0;
        res_en_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (StartE && !FlushE) begin
                    StallMul = 1'b1;
                    load_o   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                StallMul = 1'b1;
                if (FlushE) begin
                    state_d = ST_IDLE;
                end else begin
                    step_o = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                StallMul = 1'b1;
                if (FlushE) begin
                    state_d = ST_IDLE;
                end else begin
                    res_en_o = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // StartE here still belongs to the finishing instruction.
                Done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/mul_unit.sv
// Execute-stage iterative multiplier (MUL/MLA/UMULL/SMULL): radix-2 shift-add
// datapath, SMULL sign fix, MLA accumulate and NZCV flag generation.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             FlushE,
    input  logic [1:0]       MulOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [WIDTH-1:0] SrcCE,
    output logic             StallMul,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [3:0]       ALUFlags
);

    logic load, step, res_en;

    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               sign_q, sign_d;
    logic [1:0]         op_q, op_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   lo_d, hi_d;
    logic [3:0]         flags_d;
    logic               is_smull;

    mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .StartE   (StartE),
        .FlushE   (FlushE),
        .StallMul (StallMul),
        .Done     (Done),
        .load_o   (load),
        .step_o   (step),
        .res_en_o (res_en)
    );

    // Operand magnitudes: SMULL multiplies unsigned magnitudes and fixes the sign later.
    always_comb begin
        is_smull = (MulOpE == SMULL_OP);
        a_mag    = (is_smull && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        b_mag    = (is_smull && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    end

    // Shift-add next state: load on start, one conditional add and shift per step.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        op_d     = op_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            sign_d   = is_smull & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            op_d     = MulOpE;
        end else if (step) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            op_q     <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            op_q     <= op_d;
        end
    end

    // FIX-stage result shaping and flags; SrcCE is still held by the stall here.
    always_comb begin
        prod = sign_q ? -acc_q : acc_q;
        lo_d = prod[WIDTH-1:0];
        if (op_q == MLA_OP) lo_d = lo_d + SrcCE;
        hi_d = is_long_op(op_q) ? prod[2*WIDTH-1:WIDTH] : '0;
        flags_d[3] = is_long_op(op_q) ? hi_d[WIDTH-1] : lo_d[WIDTH-1];
        flags_d[2] = is_long_op(op_q) ? ~|{hi_d, lo_d} : ~|lo_d;
        flags_d[1] = 1'b0;
        flags_d[0] = 1'b0;
    end

    flopenr #(.WIDTH(WIDTH)) u_lo_reg (
        .clk(clk), .reset(reset), .en(res_en), .d(lo_d), .q(ResultLo)
    );

    flopenr #(.WIDTH(WIDTH)) u_hi_reg (
        .clk(clk), .reset(reset), .en(res_en), .d(hi_d), .q(ResultHi)
    );

    flopenr #(.WIDTH(4)) u_flag_reg (
        .clk(clk), .reset(reset), .en(res_en), .d(flags_d), .q(ALUFlags)
    );

endmodule
